// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed BCD display scanner with guard gaps, frame-synchronous value updates and leading-zero blanking
//   clk, reset_n        : clock, asynchronous active-low reset
//   en                  : scan enable (0 parks the scanner in OFF)
//   wr_valid/wr_data    : offer a new 4-digit BCD value (wr_data[15:12] is the leftmost digit)
//   wr_ready            : no update pending, a new value can be taken
//   lz_blank            : blank leading zeros (digit 0 is always shown)
//   an, digit, blank    : active-low anodes, BCD code and segment-suppress for the shared decoder
//   frame_tick          : one-cycle pulse on the last driven cycle of a frame
//   bcd_err             : sticky, an accepted value held a nibble above 9
module seg_scan_ctrl #(
  parameter int DIV_CYC   = 100000,
  parameter int GUARD_CYC = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  input  logic        lz_blank,
  output logic        wr_ready,
  output logic [3:0]  an,
  output logic [3:0]  digit,
  output logic        blank,
  output logic        frame_tick,
  output logic        bcd_err
);
  localparam int CW = $clog2(DIV_CYC);
  localparam logic [CW-1:0] G_LAST = CW'(GUARD_CYC - 1);
  localparam logic [CW-1:0] S_LAST = CW'(DIV_CYC - 1);
  typedef enum logic [1:0] {OFF, GUARD, DRIVE} state_t;
  state_t r_state, w_nstate;
  logic [CW-1:0] r_cnt, w_ncnt;
  logic [1:0] r_idx, w_nidx;
  logic [15:0] r_act, r_pend, w_nact;
  logic [3:0] r_an, r_digit, w_an, w_digit, w_nib;
  logic r_rdy, r_err, r_lz, r_blank, r_ft;
  logic w_nlz, w_lzm, w_drv, w_blank, w_ft, w_copy, w_bad;
  assign w_bad = (wr_data[15:12] > 4'd9) || (wr_data[11:8] > 4'd9) ||
                 (wr_data[7:4] > 4'd9) || (wr_data[3:0] > 4'd9);
  // Pending value becomes active at a frame boundary, or straight away while parked.
  assign w_copy = !r_rdy && (r_ft || r_state == OFF);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= OFF;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_idx   <= w_nidx;
    end
  // cnt runs across the whole slot: guard is 0..GUARD_CYC-1, drive the rest.
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt + 1'b1;
    w_nidx   = r_idx;
    if (!en) begin
      w_nstate = OFF;
      w_ncnt   = '0;
      w_nidx   = '0;
    end else if (r_state == OFF) begin
      w_nstate = GUARD;
      w_ncnt   = '0;
    end else if (r_state == GUARD && r_cnt == G_LAST) begin
      w_nstate = DRIVE;
    end else if (r_state == DRIVE && r_cnt == S_LAST) begin
      w_nstate = GUARD;
      w_ncnt   = '0;
      w_nidx   = r_idx + 1'b1;
    end
  end
  // Outputs are computed from next-cycle values so the registered copies line up with the state.
  always_comb begin
    w_nact  = w_copy ? r_pend : r_act;
    w_nib   = w_nact[{w_nidx, 2'b00} +: 4];
    w_nlz   = (r_state == GUARD && w_nstate == DRIVE) ? lz_blank : r_lz;
    w_lzm   = w_nlz && w_nidx != 2'd0 && (w_nact >> {w_nidx, 2'b00}) == 16'd0;
    w_drv   = w_nstate == DRIVE && w_nib <= 4'd9 && !w_lzm;
    w_an    = w_drv ? ~(4'b0001 << w_nidx) : 4'b1111;
    w_blank = !w_drv;
    w_digit = (w_nstate == OFF) ? 4'd0 : w_nib;
    w_ft    = w_nstate == DRIVE && w_ncnt == S_LAST && w_nidx == 2'd3;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_act   <= '0;
      r_pend  <= '0;
      r_rdy   <= 1'b1;
      r_err   <= 1'b0;
      r_lz    <= 1'b0;
      r_an    <= 4'hF;
      r_digit <= '0;
      r_blank <= 1'b1;
      r_ft    <= 1'b0;
    end else begin
      r_act   <= w_nact;
      r_lz    <= w_nlz;
      r_an    <= w_an;
      r_digit <= w_digit;
      r_blank <= w_blank;
      r_ft    <= w_ft;
      if (wr_valid && r_rdy) begin
        r_pend <= wr_data;
        r_rdy  <= 1'b0;
        r_err  <= r_err | w_bad;
      end else if (w_copy) begin
        r_rdy  <= 1'b1;
      end
    end
  assign wr_ready   = r_rdy;
  assign an         = r_an;
  assign digit      = r_digit;
  assign blank      = r_blank;
  assign frame_tick = r_ft;
  assign bcd_err    = r_err;
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The module SHALL have parameter DIV_CYC, default 100000, giving the clock cycles per digit slot (legal range 4..2^20).
REQ-002 The module SHALL have parameter GUARD_CYC, default 8, giving the all-anodes-off cycles at the start of each slot (legal range 1..DIV_CYC-2).
REQ-003 The module SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset_n, input, width 1: the reset, asynchronous and active-low.
REQ-005 The module SHALL have port en, input, width 1: scan enable.
REQ-006 The module SHALL have port wr_valid, input, width 1: new display value offered.
REQ-007 The module SHALL have port wr_data, input, width 16: four BCD digits; [15:12] is digit 3 (leftmost) and [3:0] is digit 0 (rightmost).
REQ-008 The module SHALL have port lz_blank, input, width 1: leading-zero blanking enable.
REQ-009 The module SHALL have port wr_ready, output, width 1: a pending value can be accepted.
REQ-010 The module SHALL have port an, output, width 4: digit anodes, active-low, one-hot-low or all-high.
REQ-011 The module SHALL have port digit, output, width 4: the BCD code sent to the shared decoder.
REQ-012 The module SHALL have port blank, output, width 1: suppress all decoder segment outputs.
REQ-013 The module SHALL have port frame_tick, output, width 1: one-cycle pulse at the end of each full 4-digit frame.
REQ-014 The module SHALL have port bcd_err, output, width 1: sticky flag, set when an illegal nibble is accepted.

Function
REQ-015 The module SHALL register all outputs (no combinational input-to-output paths).
REQ-016 The module SHALL implement FSM states OFF, GUARD and DRIVE, with slot counter cnt and digit index idx (0..3).
REQ-017 In OFF, the module SHALL hold an=1111, blank=1 and idx=0; en=1 SHALL cause a move to GUARD with cnt=0.
REQ-018 In GUARD, the module SHALL hold an=1111 and blank=1, present digit=active[idx], and move to DRIVE after exactly GUARD_CYC cycles.
REQ-019 In DRIVE, the module SHALL drive an[idx]=0 and blank=0 for DIV_CYC-GUARD_CYC cycles, then advance idx (3 wraps to 0) and return to GUARD.
REQ-020 The full slot (GUARD plus DRIVE) SHALL last exactly DIV_CYC cycles, and a frame SHALL last exactly 4*DIV_CYC cycles.
REQ-021 frame_tick SHALL pulse for 1 cycle on the final DRIVE cycle of idx=3.
REQ-022 en=0 in any state SHALL force OFF on the next edge (an=1111, idx=0, cnt=0), and re-enable SHALL restart at digit 0.
REQ-023 Handshake: wr_ready=1 iff no update is pending; wr_valid&&wr_ready SHALL capture wr_data into the pending register, and wr_ready SHALL be 0 from the next cycle.
REQ-024 A pending value SHALL be copied to the active register on the frame_tick cycle, or on the next cycle if in OFF; wr_ready SHALL return to 1 on the following cycle.
REQ-025 wr_valid while wr_ready=0 SHALL be ignored, and the pending value SHALL remain unchanged.
REQ-026 A capture with any nibble >9 SHALL set bcd_err on the next cycle; bcd_err SHALL clear only on reset.
REQ-027 In DRIVE, a digit >9 SHALL display as blanked (an=1111, blank=1 for that slot), with slot timing unchanged.
REQ-028 When lz_blank=1, digit k (k=3..1) SHALL be blanked when it and all more significant digits are 0; digit 0 SHALL never be blanked by lz_blank.
REQ-029 Changes to lz_blank SHALL take effect at the next GUARD-to-DRIVE transition.

Reset
REQ-030 Assertion of reset_n=0 SHALL immediately force OFF, an=1111, blank=1, digit=0, frame_tick=0, wr_ready=1, bcd_err=0, active=0, pending cleared, and cnt=idx=0.
REQ-031 Reset mid-frame or mid-handshake SHALL discard the pending value, and after release the module SHALL restart from OFF.

Verification (DIV_CYC=8, GUARD_CYC=2)
REQ-032 Scenario: reset, en=1, load 16'h1234 while in OFF -> an sequence 1110/1101/1011/0111 with digits 4,3,2,1; each slot is 2 cycles of an=1111 plus 6 driven cycles; frame_tick every 32 cycles.
REQ-033 Scenario: load 16'h0056 mid-frame -> the old value completes its frame, the new value starts at digit 0 after frame_tick, and wr_ready is low until then.
REQ-034 Scenario: lz_blank=1 with value 16'h0007 -> only digit 0 is driven; lz_blank=1 with 16'h0000 -> only digit 0 is driven, showing 0.
REQ-035 Scenario: load 16'h12A4 -> bcd_err=1 the next cycle; the digit 1 slot shows an=1111; bcd_err persists after a later legal load.
REQ-036 Scenario: en=0 during the idx=2 DRIVE slot -> an=1111 on the next edge; en=1 restarts at idx=0 after GUARD_CYC cycles.
REQ-037 Scenario: reset_n pulsed low mid-DRIVE with an update pending -> outputs are at reset values immediately, and active=0 after release.
